pea_result_reader: RTL and testbench

PEA_RESULT_READER -- requirements
Module: pea_result_reader

---
 rtl/pea_pkg.sv | 22 ++
 rtl/pea_result_reader.sv | 118 +++++++++++
 tb/tb_pea_result_reader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the PEA result reader: state encoding and parameter defaults.
// Also holds the small helper that decides when the two output FIFOs are out of step.
package pea_pkg;

  localparam int PEA_WIDTH   = 32;
  localparam int PEA_POP_W   = 5;
  localparam int PEA_TIMEOUT = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_READ    = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_PRESENT = 3'd3;
  localparam state_t ST_FLUSH   = 3'd4;

  // True when exactly one of the two FIFOs is empty.
  function automatic logic is_unbalanced(input logic res_empty, input logic sts_empty);
    return res_empty ^ sts_empty;
  endfunction

endpackage

// File: rtl/pea_result_reader.sv
// Pops matched result/status word pairs from the PEA output FIFOs and presents them
// to a valid/ready consumer; also supports flushing and flags persistent FIFO imbalance.
module pea_result_reader
  import pea_pkg::*;
#(
  parameter int WIDTH   = PEA_WIDTH,
  parameter int POP_W   = PEA_POP_W,
  parameter int TIMEOUT = PEA_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POP_W-1:0] result_pop,
  input  logic [POP_W-1:0] status_pop,
  input  logic [WIDTH-1:0] result_data,
  input  logic [WIDTH-1:0] status_data,
  output logic             rd_en_result,
  output logic             rd_en_status,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_status,
  output logic [15:0]      rec_count,
  output logic             mismatch,
  output logic             busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_count;
  logic             res_avail;
  logic             sts_avail;
  logic             both_avail;
  logic             unbalanced;

  assign res_avail  = (result_pop != '0);
  assign sts_avail  = (status_pop != '0);
  assign both_avail = res_avail && sts_avail;
  assign unbalanced = is_unbalanced(!res_avail, !sts_avail);
  assign busy       = (state != ST_IDLE);

  // The rd_en strobes are registered and only raised when both populations were
  // non-zero on the deciding edge; nothing else pops, so they can never underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_en_result <= 1'b0;
      rd_en_status <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_status   <= '0;
      rec_count    <= '0;
    end else begin
      rd_en_result <= 1'b0;
      rd_en_status <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state <= ST_FLUSH;
          end else if (both_avail) begin
            state        <= ST_READ;
            rd_en_result <= 1'b1;
            rd_en_status <= 1'b1;
          end
        end
        ST_READ: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          out_result <= result_data;
          out_status <= status_data;
          out_valid  <= 1'b1;
          state      <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rec_count <= rec_count + 16'd1;
            state     <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          // A strobe cycle is always followed by a gap cycle so the populations settle.
          if (!rd_en_result) begin
            if (both_avail) begin
              rd_en_result <= 1'b1;
              rd_en_status <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Imbalance watchdog: counts idle cycles with exactly one FIFO empty; the flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_count <= '0;
      mismatch  <= 1'b0;
    end else if ((state == ST_IDLE) && unbalanced) begin
      if (tmo_count != TMO_W'(TIMEOUT)) begin
        tmo_count <= tmo_count + TMO_W'(1);
      end
      if (tmo_count == TMO_W'(TIMEOUT - 1)) begin
        mismatch <= 1'b1;
      end
    end else begin
      tmo_count <= '0;
    end
  end

endmodule

// File: tb/tb_pea_result_reader.sv
// Self-checking bench for pea_result_reader: FIFO environment, per-cycle model checks
// and directed scenarios with hand-computed expectations.
module tb_pea_result_reader;
  import pea_pkg::*;

  localparam int WIDTH   = 32;
  localparam int POP_W   = 5;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [POP_W-1:0] result_pop;
  logic [POP_W-1:0] status_pop;
  logic [WIDTH-1:0] result_data = '0;
  logic [WIDTH-1:0] status_data = '0;
  logic             rd_en_result;
  logic             rd_en_status;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_status;
  logic [15:0]      rec_count;
  logic             mismatch;
  logic             busy;

  // Bench-side FIFOs: tails written by stimulus, heads advanced by the pop process.
  logic [WIDTH-1:0] res_mem [64];
  logic [WIDTH-1:0] sts_mem [64];
  logic [5:0]       res_head = '0;
  logic [5:0]       res_tail = '0;
  logic [5:0]       sts_head = '0;
  logic [5:0]       sts_tail = '0;
  logic             env_clear = 1'b0;

  logic             flush_window  = 1'b0;
  logic             model_preload = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  assign result_pop = POP_W'(res_tail - res_head);
  assign status_pop = POP_W'(sts_tail - sts_head);

  always #5 clk = ~clk;

  pea_result_reader #(.WIDTH(WIDTH), .POP_W(POP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .result_pop(result_pop), .status_pop(status_pop),
    .result_data(result_data), .status_data(status_data),
    .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_status(out_status),
    .rec_count(rec_count), .mismatch(mismatch), .busy(busy)
  );

  // FIFO read port: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (env_clear) begin
      res_head <= res_tail;
      sts_head <= sts_tail;
    end else begin
      if (rd_en_result) begin
        result_data <= res_mem[res_head];
        res_head    <= res_head + 6'd1;
      end
      if (rd_en_status) begin
        status_data <= sts_mem[sts_head];
        sts_head    <= sts_head + 6'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic pushResult(input logic [WIDTH-1:0] v);
    res_mem[res_tail] = v;
    res_tail = res_tail + 6'd1;
  endtask

  task automatic pushStatus(input logic [WIDTH-1:0] v);
    sts_mem[sts_tail] = v;
    sts_tail = sts_tail + 6'd1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] s);
    pushResult(r);
    pushStatus(s);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    env_clear = 1'b1;
    @(negedge clk);
    env_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitValid(input string name, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && !out_valid; i++) @(negedge clk);
    if (!out_valid) checkOutput({name, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic takeRecord(input string name, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] s);
    waitValid(name, 20);
    checkOutput({name, "_result"}, out_result, r);
    checkOutput({name, "_status"}, out_status, s);
    @(negedge clk);
  endtask

  // Per-cycle model: counts acceptances, tracks the imbalance timeout and the
  // pair most recently popped, which is what any presented record must show.
  initial begin : compare_proc
    logic [15:0]      m_cnt;
    int               m_tmo;
    logic             m_mism;
    logic [WIDTH-1:0] m_res;
    logic [WIDTH-1:0] m_sts;
    m_cnt = '0; m_tmo = 0; m_mism = 1'b0; m_res = '0; m_sts = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        checkOutput("cyc_rst_ctrl", {27'd0, rd_en_result, rd_en_status, out_valid, busy, mismatch}, 32'd0);
        checkOutput("cyc_rst_data", out_result | out_status | {16'd0, rec_count}, 32'd0);
        m_cnt = '0; m_tmo = 0; m_mism = 1'b0;
      end else begin
        if (model_preload) m_cnt = 16'hFFFF;
        checkOutput("cyc_rec_count", {16'd0, rec_count}, {16'd0, m_cnt});
        checkOutput("cyc_mismatch", 32'(mismatch), 32'(m_mism));
        checkOutput("cyc_rd_en_pair", 32'(rd_en_result), 32'(rd_en_status));
        if (rd_en_result || rd_en_status)
          checkOutput("cyc_rd_en_nonempty", 32'(result_pop != 0 && status_pop != 0), 32'd1);
        if (out_valid) begin
          checkOutput("cyc_out_result", out_result, m_res);
          checkOutput("cyc_out_status", out_status, m_sts);
        end
        if (flush_window) checkOutput("cyc_flush_no_valid", 32'(out_valid), 32'd0);
        if (out_valid && out_ready) m_cnt = m_cnt + 16'd1;
        if (!busy && ((result_pop == 0) != (status_pop == 0))) m_tmo++;
        else m_tmo = 0;
        if (m_tmo >= TIMEOUT) m_mism = 1'b1;
        if (rd_en_result) m_res = res_mem[res_head];
        if (rd_en_status) m_sts = sts_mem[sts_head];
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stim
    int pulses;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_rd_en", 32'(rd_en_result | rd_en_status), 32'd0);
    checkOutput("reset_busy_mismatch", 32'(busy | mismatch), 32'd0);
    checkOutput("reset_rec_count", {16'd0, rec_count}, 32'd0);
    checkOutput("reset_out_words", out_result | out_status, 32'd0);

    // Single pair with the consumer always ready.
    resetDut();
    out_ready = 1'b1;
    applyStimulus(32'h0000_002A, 32'h0000_0001);
    @(negedge clk);
    checkOutput("t1_rd_en_result", 32'(rd_en_result), 32'd1);
    checkOutput("t1_rd_en_status", 32'(rd_en_status), 32'd1);
    @(negedge clk);
    checkOutput("t1_rd_en_one_cycle", 32'(rd_en_result), 32'd0);
    checkOutput("t1_not_yet_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_result", out_result, 32'h0000_002A);
    checkOutput("t1_status", out_status, 32'h0000_0001);
    @(negedge clk);
    checkOutput("t1_valid_dropped", 32'(out_valid), 32'd0);
    checkOutput("t1_rec_count", {16'd0, rec_count}, 32'd1);

    // Back-pressure: three pairs, consumer stalls for ten cycles.
    resetDut();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'h100 + i, 32'h200 + i);
    waitValid("t2_first", 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t2_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_hold_result", out_result, 32'h100);
      checkOutput("t2_hold_no_rd_en", 32'(rd_en_result), 32'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) takeRecord("t2_drain", 32'h100 + i, 32'h200 + i);
    checkOutput("t2_rec_count", {16'd0, rec_count}, 32'd3);

    // Imbalance: two result words, no status words.
    @(negedge clk);
    rst       = 1'b1;
    env_clear = 1'b1;
    @(negedge clk);
    env_clear = 1'b0;
    pushResult(32'hA0);
    pushResult(32'hA1);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("t3_no_mismatch_at_15", 32'(mismatch), 32'd0);
    checkOutput("t3_no_rd_en", 32'(rd_en_result), 32'd0);
    @(negedge clk);
    checkOutput("t3_mismatch_at_16", 32'(mismatch), 32'd1);
    pushStatus(32'h55);
    takeRecord("t3_drain", 32'hA0, 32'h55);
    checkOutput("t3_mismatch_sticky", 32'(mismatch), 32'd1);
    checkOutput("t3_rec_count", {16'd0, rec_count}, 32'd1);

    // Flush four pairs from IDLE.
    resetDut();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(32'h400 + i, 32'h410 + i);
    flush        = 1'b1;
    flush_window = 1'b1;
    pulses       = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (rd_en_result) pulses++;
    end
    flush_window = 1'b0;
    checkOutput("t4_pulses", 32'(pulses), 32'd4);
    checkOutput("t4_pops_empty", 32'(result_pop) | 32'(status_pop), 32'd0);
    checkOutput("t4_rec_count", {16'd0, rec_count}, 32'd0);
    checkOutput("t4_idle", 32'(busy), 32'd0);

    // Reset during PRESENT abandons the record; the rest still drain.
    resetDut();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'h300 + i, 32'h310 + i);
    waitValid("t5_first", 20);
    checkOutput("t5_presented", out_result, 32'h300);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_ctrl", {27'd0, rd_en_result, rd_en_status, out_valid, busy, mismatch}, 32'd0);
    checkOutput("t5_async_data", out_result | out_status | {16'd0, rec_count}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    takeRecord("t5_drain1", 32'h301, 32'h311);
    takeRecord("t5_drain2", 32'h302, 32'h312);
    checkOutput("t5_rec_count", {16'd0, rec_count}, 32'd2);

    // rec_count wraps from 0xFFFF.
    resetDut();
    out_ready = 1'b0;
    force dut.rec_count = 16'hFFFF;
    model_preload = 1'b1;
    @(negedge clk);
    release dut.rec_count;
    model_preload = 1'b0;
    checkOutput("t6_preloaded", {16'd0, rec_count}, 32'h0000_FFFF);
    out_ready = 1'b1;
    applyStimulus(32'h600, 32'h601);
    takeRecord("t6_pair", 32'h600, 32'h601);
    checkOutput("t6_wrapped", {16'd0, rec_count}, 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
